// File: rtl/ahblite_busmatrix_inputstage_pkg.sv
// ---------------------------------------------------------------------------
// ahblite_busmatrix_inputstage_pkg
//
// Definitions shared by the bus matrix:
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HRESP encodings (OKAY/ERROR)
//   - input-stage state enum (PASS/HELD)
//   - helper that maps a held transfer type to the type shown on replay
// ---------------------------------------------------------------------------
package ahblite_busmatrix_inputstage_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HELD = 1'b1
    } istage_state_e;

    // A replayed transfer reaches the output stage after the arbiter has had
    // a chance to switch away from this port.  The burst context that made it
    // SEQ is therefore lost, so it has to be presented as NONSEQ.
    function automatic logic [1:0] replay_trans(input logic [1:0] t);
        return (t == HTRANS_SEQ) ? HTRANS_NONSEQ : t;
    endfunction

endpackage

// File: rtl/ahblite_busmatrix_inputstage.sv
// ---------------------------------------------------------------------------
// ahblite_busmatrix_inputstage
//
// Per-master input stage of the AHB-Lite bus matrix.  Passes the master's
// address phase straight through to the decoder.  If no output stage accepts
// it in the same cycle, the stage captures it, stalls the master and replays
// it from the capture registers until it is accepted.  It also tracks whether
// this port owns a data phase, so HREADYOUT/HRESP come from the right source.
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL..HPROT, HREADY   master address phase and bus ready (HREADY is
//                         HREADYOUT fed back)
//   HREADYOUT, HRESP      ready/response to the master
//   *_Inputstage          address phase presented to the decoder
//   ACTIVE_Decoder        presented address phase accepted this cycle
//   HREADYOUT_Decoder,
//   HRESP_Decoder         ready/response from the slave owning the data phase
// ---------------------------------------------------------------------------
module ahblite_busmatrix_inputstage
    import ahblite_busmatrix_inputstage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HREADY,

    output logic                  HREADYOUT,
    output logic                  HRESP,

    output logic                  HSEL_Inputstage,
    output logic [ADDR_WIDTH-1:0] HADDR_Inputstage,
    output logic [1:0]            HTRANS_Inputstage,
    output logic                  HWRITE_Inputstage,
    output logic [2:0]            HSIZE_Inputstage,
    output logic [2:0]            HBURST_Inputstage,
    output logic [3:0]            HPROT_Inputstage,

    input  logic                  ACTIVE_Decoder,
    input  logic                  HREADYOUT_Decoder,
    input  logic                  HRESP_Decoder
);

    istage_state_e         state, state_nxt;
    logic                  dphase;
    logic                  trans_req;
    logic                  capture;

    logic [ADDR_WIDTH-1:0] haddr_p0;
    logic [1:0]            htrans_p0;
    logic                  hwrite_p0;
    logic [2:0]            hsize_p0;
    logic [2:0]            hburst_p0;
    logic [3:0]            hprot_p0;

    // New NONSEQ/SEQ address phase offered by the master this cycle.
    assign trans_req = HSEL & HTRANS[1] & HREADY;

    // Capture only when nobody takes the transfer in the cycle it is offered.
    assign capture   = (state == ST_PASS) & trans_req & ~ACTIVE_Decoder;

    // ---- state register ---------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PASS: if (capture)        state_nxt = ST_HELD;
            ST_HELD: if (ACTIVE_Decoder) state_nxt = ST_PASS;
            default:                     state_nxt = ST_PASS;
        endcase
    end

    // ---- address-phase capture (stage p0) ---------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_p0  <= '0;
            htrans_p0 <= HTRANS_IDLE;
            hwrite_p0 <= 1'b0;
            hsize_p0  <= '0;
            hburst_p0 <= '0;
            hprot_p0  <= '0;
        end else if (capture) begin
            haddr_p0  <= HADDR;
            htrans_p0 <= HTRANS;
            hwrite_p0 <= HWRITE;
            hsize_p0  <= HSIZE;
            hburst_p0 <= HBURST;
            hprot_p0  <= HPROT;
        end
    end

    // ---- decoder-side address phase ---------------------------------------
    always_comb begin
        HSEL_Inputstage   = HSEL;
        HADDR_Inputstage  = HADDR;
        HTRANS_Inputstage = HSEL ? HTRANS : HTRANS_IDLE;
        HWRITE_Inputstage = HWRITE;
        HSIZE_Inputstage  = HSIZE;
        HBURST_Inputstage = HBURST;
        HPROT_Inputstage  = HPROT;
        if (state == ST_HELD) begin
            // The master may already be driving something else; only the
            // captured copy is trustworthy while the replay is pending.
            HSEL_Inputstage   = 1'b1;
            HADDR_Inputstage  = haddr_p0;
            HTRANS_Inputstage = replay_trans(htrans_p0);
            HWRITE_Inputstage = hwrite_p0;
            HSIZE_Inputstage  = hsize_p0;
            HBURST_Inputstage = hburst_p0;
            HPROT_Inputstage  = hprot_p0;
        end
    end

    // ---- data-phase tracking (stage p1) -----------------------------------
    // The flag advances only when the current data phase (if any) completes,
    // so an accepted replay and the end of the previous data phase can share
    // one edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase <= 1'b0;
        end else if (!dphase || HREADYOUT_Decoder) begin
            dphase <= ACTIVE_Decoder & HTRANS_Inputstage[1];
        end
    end

    // ---- master-side response ---------------------------------------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        if (dphase) begin
            HREADYOUT = HREADYOUT_Decoder;
            HRESP     = HRESP_Decoder;
        end
        if (state == ST_HELD) begin
            HREADYOUT = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
module tb_ahblite_busmatrix_inputstage;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    // {HSIZE, HBURST, HPROT}
    localparam logic [9:0] A0 = 10'h113;
    localparam logic [9:0] AG = 10'h2EC;
    localparam logic [31:0] GADDR = 32'hDEAD_0000;

    typedef struct {
        logic        rst_n;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [9:0]  attr;
        logic        act;
        logic        rdyd;
        logic        respd;
        logic        e_sel;
        logic [31:0] e_addr;
        logic [1:0]  e_trans;
        logic        e_wr;
        logic [9:0]  e_attr;
        logic        e_rdy;
        logic        e_resp;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic        HSEL_Inputstage;
    logic [31:0] HADDR_Inputstage;
    logic [1:0]  HTRANS_Inputstage;
    logic        HWRITE_Inputstage;
    logic [2:0]  HSIZE_Inputstage;
    logic [2:0]  HBURST_Inputstage;
    logic [3:0]  HPROT_Inputstage;
    logic        ACTIVE_Decoder;
    logic        HREADYOUT_Decoder;
    logic        HRESP_Decoder;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahblite_busmatrix_inputstage #(.ADDR_WIDTH(32)) dut (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .HSEL              (HSEL),
        .HADDR             (HADDR),
        .HTRANS            (HTRANS),
        .HWRITE            (HWRITE),
        .HSIZE             (HSIZE),
        .HBURST            (HBURST),
        .HPROT             (HPROT),
        .HREADY            (HREADY),
        .HREADYOUT         (HREADYOUT),
        .HRESP             (HRESP),
        .HSEL_Inputstage   (HSEL_Inputstage),
        .HADDR_Inputstage  (HADDR_Inputstage),
        .HTRANS_Inputstage (HTRANS_Inputstage),
        .HWRITE_Inputstage (HWRITE_Inputstage),
        .HSIZE_Inputstage  (HSIZE_Inputstage),
        .HBURST_Inputstage (HBURST_Inputstage),
        .HPROT_Inputstage  (HPROT_Inputstage),
        .ACTIVE_Decoder    (ACTIVE_Decoder),
        .HREADYOUT_Decoder (HREADYOUT_Decoder),
        .HRESP_Decoder     (HRESP_Decoder)
    );

    function automatic vec_t mk(
        input logic rst_n, input logic sel, input logic [31:0] addr,
        input logic [1:0] trans, input logic wr, input logic [9:0] attr,
        input logic act, input logic rdyd, input logic respd,
        input logic e_sel, input logic [31:0] e_addr, input logic [1:0] e_trans,
        input logic e_wr, input logic [9:0] e_attr, input logic e_rdy,
        input logic e_resp);
        vec_t v;
        v.rst_n = rst_n; v.sel = sel; v.addr = addr; v.trans = trans;
        v.wr = wr; v.attr = attr; v.act = act; v.rdyd = rdyd; v.respd = respd;
        v.e_sel = e_sel; v.e_addr = e_addr; v.e_trans = e_trans;
        v.e_wr = e_wr; v.e_attr = e_attr; v.e_rdy = e_rdy; v.e_resp = e_resp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(posedge HCLK);
        #2;
        HRESETn           = v.rst_n;
        HSEL              = v.sel;
        HADDR             = v.addr;
        HTRANS            = v.trans;
        HWRITE            = v.wr;
        {HSIZE, HBURST, HPROT} = v.attr;
        ACTIVE_Decoder    = v.act;
        HREADYOUT_Decoder = v.rdyd;
        HRESP_Decoder     = v.respd;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk("hsel_is",   idx, {31'd0, HSEL_Inputstage},   {31'd0, e.e_sel});
        chk("haddr_is",  idx, HADDR_Inputstage,           e.e_addr);
        chk("htrans_is", idx, {30'd0, HTRANS_Inputstage}, {30'd0, e.e_trans});
        chk("hwrite_is", idx, {31'd0, HWRITE_Inputstage}, {31'd0, e.e_wr});
        chk("attr_is",   idx,
            {22'd0, HSIZE_Inputstage, HBURST_Inputstage, HPROT_Inputstage},
            {22'd0, e.e_attr});
        chk("hreadyout", idx, {31'd0, HREADYOUT}, {31'd0, e.e_rdy});
        chk("hresp",     idx, {31'd0, HRESP},     {31'd0, e.e_resp});
    endtask

    initial begin
        logic [31:0] ra;
        HRESETn = 1'b1;
        HSEL = 1'b0; HADDR = '0; HTRANS = ID; HWRITE = 1'b0;
        HSIZE = '0; HBURST = '0; HPROT = '0;
        ACTIVE_Decoder = 1'b0; HREADYOUT_Decoder = 1'b1; HRESP_Decoder = 1'b0;
        #1 HRESETn = 1'b0;

        //          rst sel addr          tr  wr attr act rdd rsd | esel eaddr        etr ewr eattr rdy rsp
        // reset, HSEL=0 forces IDLE toward decoder
        vecs.push_back(mk(0, 0, 32'h0,        NS, 0, A0, 0, 1, 0,   0, 32'h0,        ID, 0, A0, 1, 0));
        // uncontended NONSEQ accepted immediately
        vecs.push_back(mk(1, 1, 32'h100,      NS, 0, A0, 1, 1, 0,   1, 32'h100,      NS, 0, A0, 1, 0));
        // data phase: two wait states
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 0,   0, 32'h0,        ID, 0, A0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 0,   0, 32'h0,        ID, 0, A0, 0, 0));
        // data phase completes; contended NONSEQ 0x200 offered
        vecs.push_back(mk(1, 1, 32'h200,      NS, 1, A0, 0, 1, 0,   1, 32'h200,      NS, 1, A0, 1, 0));
        // HELD: master inputs deliberately garbage, captured copy shown
        vecs.push_back(mk(1, 0, GADDR,        ID, 0, AG, 0, 1, 0,   1, 32'h200,      NS, 1, A0, 0, 0));
        vecs.push_back(mk(1, 0, GADDR,        ID, 0, AG, 0, 1, 0,   1, 32'h200,      NS, 1, A0, 0, 0));
        vecs.push_back(mk(1, 0, GADDR,        ID, 0, AG, 1, 1, 0,   1, 32'h200,      NS, 1, A0, 0, 0));
        // replay's data phase; SEQ 0x204 offered and blocked
        vecs.push_back(mk(1, 1, 32'h204,      SQ, 1, A0, 0, 1, 0,   1, 32'h204,      SQ, 1, A0, 1, 0));
        // held SEQ presented as NONSEQ, accepted
        vecs.push_back(mk(1, 0, GADDR,        SQ, 0, AG, 1, 1, 0,   1, 32'h204,      NS, 1, A0, 0, 0));
        // two-cycle ERROR
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 1,   0, 32'h0,        ID, 0, A0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 1, 1,   0, 32'h0,        ID, 0, A0, 1, 1));
        // no data phase: decoder response ignored
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 1,   0, 32'h0,        ID, 0, A0, 1, 0));
        // reset mid-HELD
        vecs.push_back(mk(1, 1, 32'h500,      NS, 1, A0, 0, 1, 0,   1, 32'h500,      NS, 1, A0, 1, 0));
        vecs.push_back(mk(1, 0, GADDR,        ID, 0, AG, 0, 1, 0,   1, 32'h500,      NS, 1, A0, 0, 0));
        vecs.push_back(mk(0, 0, 32'hABC,      NS, 0, AG, 0, 0, 1,   0, 32'hABC,      ID, 0, AG, 1, 0));
        // BUSY never captured
        vecs.push_back(mk(1, 1, 32'h600,      BZ, 0, A0, 0, 0, 1,   1, 32'h600,      BZ, 0, A0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h604,      ID, 0, A0, 0, 0, 1,   1, 32'h604,      ID, 0, A0, 1, 0));
        // reset mid-data-phase
        vecs.push_back(mk(1, 1, 32'h700,      NS, 0, A0, 1, 1, 0,   1, 32'h700,      NS, 0, A0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 1,   0, 32'h0,        ID, 0, A0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        ID, 0, A0, 0, 0, 1,   0, 32'h0,        ID, 0, A0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        ID, 0, A0, 0, 0, 1,   0, 32'h0,        ID, 0, A0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Stall-length sweep: capture, hold n cycles, replay, finish data phase.
        for (int n = 1; n <= 4; n++) begin
            ra = $urandom & 32'h0FFF_FFFC;
            apply(mk(1, 1, ra, NS, 1, A0, 0, 1, 0,   1, ra, NS, 1, A0, 1, 0), 100 + 10 * n);
            for (int k = 1; k < n; k++)
                apply(mk(1, 0, GADDR, ID, 0, AG, 0, 1, 0,   1, ra, NS, 1, A0, 0, 0), 100 + 10 * n + k);
            apply(mk(1, 0, GADDR, ID, 0, AG, 1, 0, 0,   1, ra, NS, 1, A0, 0, 0), 100 + 10 * n + 5);
            apply(mk(1, 0, 32'h0, ID, 0, A0, 0, 0, 0,   0, 32'h0, ID, 0, A0, 0, 0), 100 + 10 * n + 6);
            apply(mk(1, 0, 32'h0, ID, 0, A0, 0, 1, 0,   0, 32'h0, ID, 0, A0, 1, 0), 100 + 10 * n + 7);
            apply(mk(1, 0, 32'h0, ID, 0, A0, 0, 0, 1,   0, 32'h0, ID, 0, A0, 1, 0), 100 + 10 * n + 8);
        end

        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
